// File: rtl/frame_arbiter_pkg.sv
// Shared types and default sizing for the frame arbiter.
// Holds the FSM encoding and the default channel, sample and word-width constants.
package frame_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1
  } state_e;

  localparam int DEF_N_CHANNELS = 4;
  localparam int DEF_N_SAMPLES  = 8;
  localparam int DEF_BIT_WIDTH  = 32;

  // A single requester still needs a 1-bit channel id.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_arbiter_rr_select.sv
// Combinational round-robin search: first asserted request at or above prio,
// wrapping modulo N.
module rr_select #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] prio,
  output logic [IW-1:0] grant,
  output logic          any
);

  // One spare bit so prio + offset cannot overflow before the wrap compare.
  logic [IW:0] slot;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    slot  = '0;
    for (int i = 0; i < N; i++) begin
      slot = {1'b0, prio} + (IW+1)'(i);
      if (slot >= (IW+1)'(N)) slot = slot - (IW+1)'(N);
      if (!any && req[slot[IW-1:0]]) begin
        grant = slot[IW-1:0];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_arbiter.sv
// Round-robin frame arbiter: grants one serial requester at a time for a full
// frame of N_SAMPLES words and passes its words through to a shared deserializer.
//
// state | meaning
// IDLE  | no grant; arbitrate among requesters this cycle
// BURST | forward granted channel until N_SAMPLES words have transferred
module frame_arbiter
  import frame_arbiter_pkg::*;
#(
  parameter int N_CHANNELS = DEF_N_CHANNELS,
  parameter int N_SAMPLES  = DEF_N_SAMPLES,
  parameter int BIT_WIDTH  = DEF_BIT_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_CHANNELS-1:0]          recv_val,
  output logic [N_CHANNELS-1:0]          recv_rdy,
  input  logic [BIT_WIDTH-1:0]           recv_msg [N_CHANNELS],
  output logic                           send_val,
  input  logic                           send_rdy,
  output logic [BIT_WIDTH-1:0]           send_msg,
  output logic [idx_w(N_CHANNELS)-1:0]   send_chan,
  output logic                           send_last
);

  localparam int CHAN_W = idx_w(N_CHANNELS);
  localparam int CNT_W  = $clog2(N_SAMPLES) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_SAMPLES - 1);
  localparam logic [CHAN_W-1:0] LAST_CH  = CHAN_W'(N_CHANNELS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CHAN_W-1:0]   grant_q, grant_d;
  logic [CHAN_W-1:0]   prio_q,  prio_d;
  logic [CHAN_W-1:0]   rr_grant;
  logic                rr_any;

  rr_select #(
    .N  (N_CHANNELS),
    .IW (CHAN_W)
  ) u_rr_select (
    .req   (recv_val),
    .prio  (prio_q),
    .grant (rr_grant),
    .any   (rr_any)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    grant_d   = grant_q;
    prio_d    = prio_q;
    send_val  = 1'b0;
    send_msg  = '0;
    recv_rdy  = '0;
    send_chan = '0;
    send_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (rr_any) begin
          grant_d = rr_grant;
          state_d = BURST;
        end
      end
      BURST: begin
        // Pure pass-through: the granted channel sees the deserializer's ready.
        send_val           = recv_val[grant_q];
        send_msg           = recv_msg[grant_q];
        recv_rdy[grant_q]  = send_rdy;
        send_chan          = grant_q;
        send_last          = (count_q == LAST_CNT);
        if (send_val && send_rdy) begin
          if (count_q == LAST_CNT) begin
            count_d = '0;
            prio_d  = (grant_q == LAST_CH) ? '0 : grant_q + CHAN_W'(1);
            state_d = IDLE;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      grant_q <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: tb/tb_frame_arbiter.sv
// Scoreboard bench for frame_arbiter: expected words are queued as frames are
// requested and popped as the arbiter forwards them.
module tb_frame_arbiter;

  localparam int NC = 4;
  localparam int NS = 8;
  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] recv_val, recv_rdy;
  logic [BW-1:0] recv_msg [NC];
  logic          send_val, send_rdy, send_last;
  logic [BW-1:0] send_msg;
  logic [1:0]    send_chan;

  logic [2:0]    recv_val3, recv_rdy3;
  logic [BW-1:0] recv_msg3 [3];
  logic          send_val3, send_rdy3, send_last3;
  logic [BW-1:0] send_msg3;
  logic [1:0]    send_chan3;

  always #5 clk = ~clk;

  frame_arbiter #(.N_CHANNELS(NC), .N_SAMPLES(NS), .BIT_WIDTH(BW)) dut (
    .clk(clk), .reset(reset),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
    .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
    .send_chan(send_chan), .send_last(send_last)
  );

  frame_arbiter #(.N_CHANNELS(3), .N_SAMPLES(NS), .BIT_WIDTH(BW)) dut3 (
    .clk(clk), .reset(reset),
    .recv_val(recv_val3), .recv_rdy(recv_rdy3), .recv_msg(recv_msg3),
    .send_val(send_val3), .send_rdy(send_rdy3), .send_msg(send_msg3),
    .send_chan(send_chan3), .send_last(send_last3)
  );

  typedef struct {
    int            chan;
    logic [BW-1:0] msg;
    bit            last;
    bit            first;
  } exp_t;

  exp_t          sb [$];
  int            starts [$];
  bit   [NC-1:0] en;
  int            idx [NC];
  int            lim [NC];
  logic [BW-1:0] base [NC];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            n3 = 0;
  int            t0;

  logic          s_val, s_last;
  logic [NC-1:0] s_rdy;
  logic [1:0]    s_chan;
  logic [BW-1:0] s_msg;
  logic          s3_val, s3_last;
  logic [1:0]    s3_chan;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive_src();
    for (int c = 0; c < NC; c++) begin
      recv_val[c] = en[c] && (idx[c] < lim[c]);
      recv_msg[c] = base[c] + BW'(idx[c]);
    end
  endtask

  task automatic push_frame(input int c, input int from);
    for (int i = 0; i < NS; i++)
      sb.push_back('{chan: c, msg: base[c] + BW'(from + i), last: (i == NS-1), first: (i == 0)});
  endtask

  // One clock: observe at negedge, then advance sources just after posedge.
  task automatic tick();
    exp_t          e;
    logic [NC-1:0] adv;
    @(negedge clk);
    cyc++;
    s_val = send_val; s_last = send_last; s_rdy = recv_rdy;
    s_chan = send_chan; s_msg = send_msg;
    s3_val = send_val3; s3_last = send_last3; s3_chan = send_chan3;
    if (send_val3 && send_rdy3) n3++;
    adv = recv_val & recv_rdy;
    if (send_val && send_rdy) begin
      check("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("xfer_chan", send_chan, e.chan);
        check("xfer_msg", send_msg, e.msg);
        check("xfer_last", send_last, e.last);
        if (e.first) starts.push_back(cyc);
      end
      check("rdy_onehot", recv_rdy, NC'(1) << send_chan);
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) if (adv[c]) idx[c]++;
    drive_src();
  endtask

  task automatic run_until_size(input int s, input int budget);
    int n = 0;
    while (sb.size() > s && n < budget) begin
      tick();
      n++;
    end
    check("sb_level", sb.size(), s);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    en = '0;
    for (int c = 0; c < NC; c++) begin
      idx[c] = 0;
      lim[c] = 0;
      base[c] = BW'(c) << 8;
    end
    drive_src();
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    send_rdy = 1'b1;
    recv_val3 = '0;
    send_rdy3 = 1'b1;
    for (int c = 0; c < 3; c++) recv_msg3[c] = BW'(32'h30 + c);
    do_reset();
    check("rst_send_val", s_val, 0);
    check("rst_recv_rdy", s_rdy, 0);
    check("rst_send_last", s_last, 0);
    check("rst_send_chan", s_chan, 0);

    // Single requester ch2, words 0x10..0x17.
    base[2] = 32'h10; lim[2] = NS;
    push_frame(2, 0);
    starts.delete();
    en[2] = 1'b1; drive_src(); t0 = cyc;
    tick();
    check("t1_idle_val", s_val, 0);
    run_until_size(0, 20);
    check("t1_nframes", starts.size(), 1);
    foreach (starts[i]) check("t1_start", starts[i], t0 + 2);
    tick();
    check("t1_after_val", s_val, 0);
    check("t1_after_chan", s_chan, 0);

    // All channels continuously valid: order 0,1,2,3,0 with one idle cycle each.
    do_reset();
    lim[0] = 2*NS; lim[1] = NS; lim[2] = NS; lim[3] = NS;
    push_frame(0, 0); push_frame(1, 0); push_frame(2, 0); push_frame(3, 0); push_frame(0, NS);
    starts.delete();
    en = '1; drive_src();
    run_until_size(0, 80);
    check("t2_nframes", starts.size(), 5);
    for (int i = 1; i < starts.size(); i++) check("t2_frame_gap", starts[i] - starts[i-1], NS + 1);
    en = '0; drive_src();

    // Downstream stall after four words.
    do_reset();
    lim[1] = NS;
    push_frame(1, 0);
    en[1] = 1'b1; drive_src();
    run_until_size(NS - 4, 30);
    send_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_stall_val", s_val, 1);
      check("t3_stall_msg", s_msg, base[1] + 4);
      check("t3_stall_last", s_last, 0);
    end
    send_rdy = 1'b1;
    run_until_size(0, 20);

    // Granted ch1 goes quiet mid-frame while ch0 requests.
    do_reset();
    lim[0] = NS; lim[1] = NS;
    push_frame(1, 0); push_frame(0, 0);
    en[1] = 1'b1; drive_src();
    run_until_size(2*NS - 3, 30);
    en[1] = 1'b0; en[0] = 1'b1; drive_src();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_gap_val", s_val, 0);
      check("t4_gap_chan", s_chan, 1);
      check("t4_ch0_rdy", s_rdy[0], 0);
    end
    en[1] = 1'b1; drive_src();
    run_until_size(0, 40);
    en = '0; drive_src();

    // Reset during word 5 abandons the frame and clears the rotating priority.
    lim[2] = NS;
    for (int i = 0; i < 5; i++)
      sb.push_back('{chan: 2, msg: base[2] + BW'(i), last: 1'b0, first: (i == 0)});
    en[2] = 1'b1; drive_src();
    run_until_size(0, 20);
    reset = 1'b0; send_rdy = 1'b0;
    tick();
    reset = 1'b1; send_rdy = 1'b1; en = '0;
    for (int c = 0; c < NC; c++) idx[c] = 0;
    drive_src();
    tick();
    check("t5_val", s_val, 0);
    check("t5_chan", s_chan, 0);
    check("t5_last", s_last, 0);
    lim[0] = NS; lim[3] = NS;
    push_frame(0, 0); push_frame(3, 0);
    starts.delete();
    en = 4'b1001; drive_src(); t0 = cyc;
    run_until_size(0, 40);
    check("t5_nframes", starts.size(), 2);
    if (starts.size() == 2) begin
      check("t5_first_start", starts[0], t0 + 2);
      check("t5_ch3_gap", starts[1] - starts[0], NS + 1);
    end
    en = '0; drive_src();

    // Three-channel instance: grant 2 completes, priority wraps to 0.
    recv_val3 = 3'b100;
    n3 = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (s3_val && s3_last) break;
    end
    check("t6_last_seen", s3_val && s3_last, 1);
    check("t6_chan", s3_chan, 2);
    check("t6_words", n3, NS);
    recv_val3 = 3'b011;
    tick();
    check("t6_idle_val", s3_val, 0);
    tick();
    check("t6_wrap_val", s3_val, 1);
    check("t6_wrap_chan", s3_chan, 0);
    recv_val3 = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_arbiter.md
FRAME_ARBITER -- requirements
Module: frame_arbiter

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 4: number of serial requesters sharing one deserializer.
REQ-002 SHALL have parameter N_SAMPLES, default 8: words per frame; must match the downstream deserializer's N_SAMPLES.
REQ-003 SHALL have parameter BIT_WIDTH, default 32: word width.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on posedge clk.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset (0 = reset, sampled on posedge clk).
REQ-006 SHALL have port recv_val, input, N_CHANNELS: per-channel word valid.
REQ-007 SHALL have port recv_rdy, output, N_CHANNELS: per-channel word ready.
REQ-008 SHALL have port recv_msg, input, N_CHANNELS x BIT_WIDTH (unpacked array): per-channel word.
REQ-009 SHALL have port send_val, output, 1: word valid to the deserializer.
REQ-010 SHALL have port send_rdy, input, 1: deserializer ready.
REQ-011 SHALL have port send_msg, output, BIT_WIDTH: forwarded word.
REQ-012 SHALL have port send_chan, output, $clog2(N_CHANNELS) (minimum 1): granted channel id.
REQ-013 SHALL have port send_last, output, 1: high with the N_SAMPLES-th word of a frame.

Function
REQ-014 SHALL implement the FSM states IDLE and BURST.
REQ-015 In IDLE, all recv_rdy SHALL be 0 and send_val SHALL be 0.
REQ-016 In IDLE with any recv_val high, the FSM SHALL latch grant = first requesting channel at or after prio, searching upward with modulo-N_CHANNELS wrap, and SHALL enter BURST next cycle.
REQ-017 In IDLE with no recv_val high, the FSM SHALL remain in IDLE.
REQ-018 In BURST, datapath: send_val = recv_val[grant]; send_msg = recv_msg[grant]; recv_rdy[grant] = send_rdy; all other recv_rdy = 0 (combinational pass-through, zero added latency, no buffering).
REQ-019 A transfer SHALL occur when send_val and send_rdy are both high; count SHALL increment by 1 per transfer.
REQ-020 count SHALL be $clog2(N_SAMPLES)+1 bits wide and SHALL never exceed N_SAMPLES-1 when registered.
REQ-021 send_last SHALL be high in BURST when count == N_SAMPLES-1, and 0 otherwise.
REQ-022 On the transfer with count == N_SAMPLES-1, the FSM SHALL clear count, set prio = (grant+1) mod N_CHANNELS (wrapping correctly for non-power-of-2 N_CHANNELS), and return to IDLE.
REQ-023 Grant SHALL be held for the whole frame; the granted channel dropping recv_val mid-frame SHALL stall the frame, not release the grant.
REQ-024 Other channels raising recv_val mid-frame SHALL have no effect until the next IDLE.
REQ-025 send_rdy low SHALL hold count, grant and state unchanged.
REQ-026 send_chan SHALL equal grant in BURST and 0 in IDLE.
REQ-027 Per-frame overhead SHALL be exactly one IDLE arbitration cycle; back-to-back frames take N_SAMPLES+1 cycles minimum.

Reset
REQ-028 With reset == 0 at posedge clk: state = IDLE, count = 0, grant = 0, prio = 0.
REQ-029 Outputs after reset: send_val = 0, all recv_rdy = 0, send_last = 0, send_chan = 0; send_msg is don't-care.
REQ-030 Reset asserted mid-BURST SHALL abandon the partial frame; the downstream deserializer is reset by the same signal (inverted at top level).

Structure
REQ-031 The shared package SHALL hold the FSM state typedef (2-bit encoding, IDLE = 0, BURST = 1) and the default N_CHANNELS, N_SAMPLES and BIT_WIDTH constants.
REQ-032 The round-robin search SHALL be a combinational sub-module rr_select (inputs: req vector, prio; outputs: grant index, any).
REQ-033 State, count, grant and prio registers SHALL use RegisterV_Reset-style registers with polarity adapted to active-low reset.

Verification
REQ-034 Only ch2 requests, 8 words 0x10..0x17 with send_rdy = 1 -> one idle cycle, then send_chan = 2 for 8 consecutive transfers, send_last on 0x17, then IDLE.
REQ-035 All 4 channels continuously valid -> frames granted in order 0,1,2,3,0, each exactly 8 words, with one idle cycle between frames.
REQ-036 send_rdy low for 3 cycles after word 4 -> count holds at 4, send_val stays high, no word lost or duplicated.
REQ-037 ch1 drops recv_val after word 3 while ch0 requests -> grant stays 1, ch0 recv_rdy stays 0, frame completes when ch1 resumes.
REQ-038 reset = 0 during word 5 of a frame -> next cycle IDLE, count = 0, prio = 0; a new request from ch3 is then granted after one cycle.
REQ-039 N_CHANNELS = 3, grant = 2 completes -> prio wraps to 0.
